shift_rotate_seq: RTL and testbench
===================================

Name: shift_rotate_seq

Overview:
Parametrised sequential shifter/rotator that generalises the combinational N-bit rotator. It adds shift modes (logical and arithmetic), a variable shift amount, and carry-out. Operations run one bit-step per clock under a START/BUSY/DONE handshake. Used as a datapath unit wherever multi-bit rotates or shifts are needed at low area.

Parameters:
N, 8, data width in bits (N >= 2)
AW, $clog2(N)+1, width of shift-amount port (derived; lets AMT = N be expressed)

Ports:
CLK  input  1  system clock, all state updates on rising edge
RESET  input  1  synchronous, active-high reset
START  input  1  request; sampled only in IDLE
MODE  input  3  operation select (mode_t), captured on START
AMT  input  AW  number of single-bit steps, captured on START
X  input  N  operand, captured on START
Y  output  N  result register
COUT  output  1  last bit shifted out, or wrapped for rotates
BUSY  output  1  high while an operation is in progress
DONE  output  1  one-cycle pulse when Y is valid

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RESET).
- Reset values: Y=0, COUT=0, BUSY=0, DONE=0, state=IDLE, count=0.
- RESET has priority over everything, including mid-operation: the operation is aborted and nothing is preserved.
- States:
  - IDLE: BUSY=0. On START=1, load Y<=X, capture MODE, count<=AMT, COUT<=0. Go to DONE if AMT==0, else RUN.
  - RUN: BUSY=1. Each cycle apply one step to Y and COUT, count<=count-1. On the step where count==1, go to DONE.
  - DONE: DONE=1 and BUSY=0 for exactly one cycle, then IDLE.
- Latency: if START is sampled at edge k, DONE is high during the cycle after edge k+AMT+1. For AMT=0 that is after edge k+1, with Y=X and COUT=0.
- START is ignored in RUN and DONE; there is no queueing. A START held high in DONE is not accepted until IDLE, so back-to-back ops have a 1-cycle gap.
- X, MODE and AMT may change freely after capture.
- Y and COUT hold their final values until the next accepted START or RESET.
- Single-step rules (b = Y before the step):
  - ROL (0): Y = {b[N-2:0], b[N-1]}; COUT = b[N-1]
  - ROR (1): Y = {b[0], b[N-1:1]}; COUT = b[0]
  - SHL (2): Y = {b[N-2:0], 1'b0}; COUT = b[N-1]
  - SHR (3): Y = {1'b0, b[N-1:1]}; COUT = b[0]
  - ASR (4): Y = {b[N-1], b[N-1:1]}; COUT = b[0]
  - Codes 5-7 are reserved: Y and COUT hold, and the op still takes AMT cycles.
- AMT is executed literally, with no modulo or saturation:
  - rotate by N returns X;
  - SHL/SHR by N gives 0;
  - ASR by N gives all copies of the sign bit.

Decomposition:
- Package shift_rotate_pkg:
  - typedef enum logic [2:0] mode_t {ROL=0, ROR=1, SHL=2, SHR=3, ASR=4}
  - typedef enum logic [1:0] state_t {IDLE, RUN, DONE_S}
- Sub-module shift_step #(N): purely combinational single-step unit.
  - Inputs: b, mode. Outputs: y_next, c_next.
  - Instantiated once inside shift_rotate_seq.
  - Unit-testable on its own, exhaustively for N=8.

Test Plan:
- N=8, X=8'b10101100, ROL, AMT=1 -> after 2 cycles DONE pulses; Y=8'b01011001, COUT=1; BUSY high for exactly 1 cycle.
- X=8'b10101100, ROL, AMT=8 -> DONE after 9 cycles; Y=8'b10101100. Then ROR AMT=8 -> Y unchanged. This covers full-circle rotation in both directions.
- X=8'b10101100, ROR, AMT=3 -> Y=8'b10010101, COUT=1. X=8'b10101100, ASR, AMT=2 -> Y=8'b11101011, COUT=0.
- X=8'b10101100, SHL, AMT=3 -> Y=8'b01100000, COUT=1. SHR, AMT=8 -> Y=0. AMT=0 (any mode) -> DONE the next cycle, Y=X, COUT=0.
- START pulsed again during RUN with a different X -> ignored; the result matches the first operation. START held high continuously -> ops accepted every AMT+2 cycles.
- RESET asserted mid-RUN (ROL, AMT=8, after 3 steps) -> next edge gives Y=0, COUT=0, BUSY=0, DONE=0, no DONE pulse. A following START operates normally.

Source files
------------

// File: rtl/shift_rotate_pkg.sv
// rtl/shift_rotate_pkg.sv - shared mode and state encodings for the sequential shifter
package shift_rotate_pkg;

  typedef enum logic [2:0] {
    ROL = 3'd0,
    ROR = 3'd1,
    SHL = 3'd2,
    SHR = 3'd3,
    ASR = 3'd4
  } mode_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE_S
  } state_t;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-bit shift/rotate step
module shift_step
  import shift_rotate_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] b,
  input  logic [2:0]   mode,
  output logic [N-1:0] y_next,
  output logic         c_next
);

  always_comb begin
    y_next = b;
    c_next = 1'b0;
    case (mode)
      ROL: begin y_next = {b[N-2:0], b[N-1]};  c_next = b[N-1]; end
      ROR: begin y_next = {b[0], b[N-1:1]};    c_next = b[0];   end
      SHL: begin y_next = {b[N-2:0], 1'b0};    c_next = b[N-1]; end
      SHR: begin y_next = {1'b0, b[N-1:1]};    c_next = b[0];   end
      ASR: begin y_next = {b[N-1], b[N-1:1]};  c_next = b[0];   end
      default: begin y_next = b; c_next = 1'b0; end
    endcase
  end

endmodule

// File: rtl/shift_rotate_seq.sv
// rtl/shift_rotate_seq.sv - one-bit-per-clock shifter/rotator with START/BUSY/DONE handshake
module shift_rotate_seq
  import shift_rotate_pkg::*;
#(
  parameter int N  = 8,
  parameter int AW = $clog2(N) + 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          START,
  input  logic [2:0]    MODE,
  input  logic [AW-1:0] AMT,
  input  logic [N-1:0]  X,
  output logic [N-1:0]  Y,
  output logic          COUT,
  output logic          BUSY,
  output logic          DONE
);

  state_t        state_q;
  logic [2:0]    mode_q;
  logic [AW-1:0] count_q;
  logic [N-1:0]  y_q, y_d, y_step;
  logic          cout_q, cout_d, c_step;
  logic          busy_q, done_q;

  shift_step #(.N(N)) u_step (
    .b      (y_q),
    .mode   (mode_q),
    .y_next (y_step),
    .c_next (c_step)
  );

  // Reserved codes still burn AMT cycles but leave Y/COUT untouched.
  always_comb begin
    y_d    = y_q;
    cout_d = cout_q;
    if (mode_q <= 3'(ASR)) begin
      y_d    = y_step;
      cout_d = c_step;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      mode_q  <= 3'd0;
      count_q <= '0;
      y_q     <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      busy_q <= (state_q == RUN);
      done_q <= (state_q == DONE_S);
      case (state_q)
        IDLE: begin
          if (START) begin
            y_q     <= X;
            cout_q  <= 1'b0;
            mode_q  <= MODE;
            count_q <= AMT;
            state_q <= (AMT == '0) ? DONE_S : RUN;
          end
        end
        RUN: begin
          y_q     <= y_d;
          cout_q  <= cout_d;
          count_q <= count_q - AW'(1);
          if (count_q == AW'(1)) state_q <= DONE_S;
        end
        DONE_S:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Y    = y_q;
  assign COUT = cout_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_shift_rotate_seq.sv
// tb/tb_shift_rotate_seq.sv - directed self-checking bench for shift_rotate_seq
module tb_shift_rotate_seq;

  localparam int N  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    mode;
  logic [AW-1:0] amt;
  logic [N-1:0]  x;
  logic [N-1:0]  y;
  logic          cout, busy, done;

  int total = 0;
  int passed = 0;

  shift_rotate_seq #(.N(N), .AW(AW)) dut (
    .CLK(clk), .RESET(reset), .START(start), .MODE(mode), .AMT(amt),
    .X(x), .Y(y), .COUT(cout), .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  // Drives one operation; lat = edges from accept to DONE seen, -1 on timeout.
  task automatic run_op(input logic [N-1:0] xv, input logic [2:0] mv, input logic [AW-1:0] av,
                        output int lat, output int busy_cyc);
    @(negedge clk);
    x = xv; mode = mv; amt = av; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    x = 8'h00; mode = 3'd7; amt = '0;
    lat = -1; busy_cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      if (busy) busy_cyc++;
      @(posedge clk);
      @(negedge clk);
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mode = 3'd0; amt = '0; x = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({y, cout, busy, done} !== {8'h00, 3'b000}) $display("FAIL reset_state: got y=%h c=%b b=%b d=%b want 00 0 0 0", y, cout, busy, done);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_rol1();
    int lat, bc;
    run_op(8'b10101100, 3'd0, 4'd1, lat, bc);
    total++;
    if (y !== 8'b01011001 || cout !== 1'b1) $display("FAIL rol1_result: got y=%b c=%b want 01011001 1", y, cout);
    else passed++;
    total++;
    if (lat !== 2 || bc !== 1) $display("FAIL rol1_timing: got lat=%0d busy=%0d want 2 1", lat, bc);
    else passed++;
    @(posedge clk); @(negedge clk);
    total++;
    if (done !== 1'b0) $display("FAIL rol1_done_pulse: got done=%b want 0", done);
    else passed++;
  endtask

  task automatic test_full_circle();
    int lat, bc;
    run_op(8'b10101100, 3'd0, 4'd8, lat, bc);
    total++;
    if (y !== 8'b10101100 || cout !== 1'b0 || lat !== 9 || bc !== 8)
      $display("FAIL rol8: got y=%b c=%b lat=%0d busy=%0d want 10101100 0 9 8", y, cout, lat, bc);
    else passed++;
    run_op(8'b10101100, 3'd1, 4'd8, lat, bc);
    total++;
    if (y !== 8'b10101100 || cout !== 1'b1 || lat !== 9)
      $display("FAIL ror8: got y=%b c=%b lat=%0d want 10101100 1 9", y, cout, lat);
    else passed++;
  endtask

  task automatic test_ror_asr();
    int lat, bc;
    run_op(8'b10101100, 3'd1, 4'd3, lat, bc);
    total++;
    if (y !== 8'b10010101 || cout !== 1'b1 || lat !== 4)
      $display("FAIL ror3: got y=%b c=%b lat=%0d want 10010101 1 4", y, cout, lat);
    else passed++;
    run_op(8'b10101100, 3'd4, 4'd2, lat, bc);
    total++;
    if (y !== 8'b11101011 || cout !== 1'b0)
      $display("FAIL asr2: got y=%b c=%b want 11101011 0", y, cout);
    else passed++;
    run_op(8'b10101100, 3'd4, 4'd8, lat, bc);
    total++;
    if (y !== 8'b11111111 || cout !== 1'b1)
      $display("FAIL asr8: got y=%b c=%b want 11111111 1", y, cout);
    else passed++;
  endtask

  task automatic test_shl_shr_zero();
    int lat, bc;
    run_op(8'b10101100, 3'd2, 4'd3, lat, bc);
    total++;
    if (y !== 8'b01100000 || cout !== 1'b1)
      $display("FAIL shl3: got y=%b c=%b want 01100000 1", y, cout);
    else passed++;
    run_op(8'b10101100, 3'd3, 4'd8, lat, bc);
    total++;
    if (y !== 8'b00000000 || cout !== 1'b1)
      $display("FAIL shr8: got y=%b c=%b want 00000000 1", y, cout);
    else passed++;
    run_op(8'b10101100, 3'd2, 4'd0, lat, bc);
    total++;
    if (y !== 8'b10101100 || cout !== 1'b0 || lat !== 1 || bc !== 0)
      $display("FAIL amt0: got y=%b c=%b lat=%0d busy=%0d want 10101100 0 1 0", y, cout, lat, bc);
    else passed++;
  endtask

  task automatic test_reserved();
    int lat, bc;
    run_op(8'b10101100, 3'd5, 4'd3, lat, bc);
    total++;
    if (y !== 8'b10101100 || cout !== 1'b0 || lat !== 4 || bc !== 3)
      $display("FAIL reserved5: got y=%b c=%b lat=%0d busy=%0d want 10101100 0 4 3", y, cout, lat, bc);
    else passed++;
  endtask

  task automatic test_start_ignored();
    int lat;
    @(negedge clk);
    x = 8'b10101100; mode = 3'd0; amt = 4'd8; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 3) begin x = 8'h0F; mode = 3'd1; amt = 4'd2; start = 1'b1; end
      if (i == 4) start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (done) begin lat = i; break; end
    end
    total++;
    if (y !== 8'b10101100 || cout !== 1'b0 || lat !== 9)
      $display("FAIL start_in_run: got y=%b c=%b lat=%0d want 10101100 0 9", y, cout, lat);
    else passed++;
    start = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int first, last, n;
    logic ybad;
    first = -1; last = -1; n = 0; ybad = 1'b0;
    @(negedge clk);
    x = 8'b10101100; mode = 3'd0; amt = 4'd1; start = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 8) start = 1'b0;
      if (done) begin
        n++;
        if (first < 0) first = i;
        last = i;
        if (y !== 8'b01011001) ybad = 1'b1;
      end
    end
    total++;
    if (n !== 3 || first !== 2 || last !== 8 || ybad)
      $display("FAIL back_to_back: got n=%0d first=%0d last=%0d ybad=%b want 3 2 8 0", n, first, last, ybad);
    else passed++;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_mid_run();
    int lat, bc, nd;
    @(negedge clk);
    x = 8'b10101100; mode = 3'd0; amt = 4'd8; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({y, cout, busy, done} !== {8'h00, 3'b000})
      $display("FAIL reset_mid_run: got y=%h c=%b b=%b d=%b want 00 0 0 0", y, cout, busy, done);
    else passed++;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done || busy) nd++;
    end
    total++;
    if (nd !== 0) $display("FAIL reset_no_done: got %0d active cycles want 0", nd);
    else passed++;
    run_op(8'b10101100, 3'd0, 4'd1, lat, bc);
    total++;
    if (y !== 8'b01011001 || cout !== 1'b1 || lat !== 2)
      $display("FAIL after_reset_op: got y=%b c=%b lat=%0d want 01011001 1 2", y, cout, lat);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_rol1();
    test_full_circle();
    test_ror_asr();
    test_shl_shr_zero();
    test_reserved();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
